// File: rtl/vec_burst_reader.sv
// vec_burst_reader: read-side burst initiator for one dp_ram port.
// Takes a (base, len) command and issues sequential reads, wrapping the address.
// It captures the registered RAM data into a 2-entry buffer and streams the words
// out on valid/ready, with m_last on the final word. Reads are issued against
// credits, so backpressure can never overflow the buffer.
module vec_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH:0]   outstanding_q, outstanding_d;
  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] buf_q [2];

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            credit;

  // A read issued last cycle has its data on ram_dout now; it is captured at this edge.
  assign push    = inflight_q;
  assign m_valid = (occ_q != 2'd0);
  assign pop     = m_valid & m_ready;

  // Words already held plus the word on its way must leave room once this cycle's pop is taken.
  assign credit = {1'b0, occ_q} + {2'b00, inflight_q};
  assign issue  = (state_q == S_ISSUE) && (remaining_q != '0) &&
                  (credit < (3'd2 + {2'b00, pop}));

  assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign ram_we   = 1'b0;
  assign ram_din  = '0;
  assign ram_addr = addr_q;
  assign m_data   = buf_q[rd_ptr_q];
  // The word at the head is the last one exactly when it is the only word not yet handed over.
  assign m_last   = m_valid && (outstanding_q == (ADDR_WIDTH + 1)'(1));

  // Burst sequencing: command capture, address walk, drain and completion pulse.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = pop ? (outstanding_q - (ADDR_WIDTH + 1)'(1)) : outstanding_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_d        = base_addr;
            remaining_d   = len;
            outstanding_d = len;
            state_d       = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
          if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Leave as the final handshake happens so done follows it by one cycle.
        if (outstanding_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Buffer occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Control and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      inflight_q    <= 1'b0;
      occ_q         <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      inflight_q    <= issue;
      occ_q         <= occ_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Two-entry data buffer, written at the write pointer when read data arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (push) begin
      buf_q[wr_ptr_q] <= ram_dout;
    end
  end

endmodule

// File: tb/tb_vec_burst_reader.sv
// Testbench for vec_burst_reader: behavioural RAM with registered read and a scoreboard of expected stream words.
module tb_vec_burst_reader;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  vec_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, data valid one cycle after the address edge.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) ram_dout <= mem[ram_addr];

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_hs_cyc = -1;
  int first_valid_cyc = -1;
  logic [AW-1:0] cur_base = '0;
  bit stall_prev = 1'b0;
  logic [DW-1:0] held_data = '0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: drive m_ready at the falling edge, then check what will handshake at the next rising edge.
  task automatic step();
    exp_t e;
    int   lead;
    @(negedge clk);
    cyc++;
    m_ready = (rdy_mode == 0) ? 1'b1 : pat[cyc % 6];
    if (stall_prev) begin
      check_eq("stall_valid", m_valid, 1);
      check_eq("stall_data", m_data, held_data);
    end
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (busy) begin
      lead = (int'(ram_addr) - int'(cur_base) - hs_cnt) & (DEPTH - 1);
      check_eq("addr_lead_le2", lead <= 2, 1);
    end
    if (m_valid && m_ready) begin
      check_eq("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("m_data", m_data, e.data);
        check_eq("m_last", m_last, e.last);
        $display("[TB] word %02h last=%0b cycle %0d", m_data, m_last, cyc);
      end
      hs_cnt++;
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check_eq("busy_in_done", busy, 0);
    end
    stall_prev = m_valid && !m_ready;
    held_data  = m_data;
  endtask

  task automatic push_expect(input logic [AW-1:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = mem[(int'(base) + i) % DEPTH];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] n, input int mode, input bit inject);
    int start_cyc;
    rdy_mode = mode;
    cur_base = base;
    hs_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    first_valid_cyc = -1;
    last_hs_cyc = -1;
    push_expect(base, int'(n));
    base_addr = base;
    len = n;
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
    check_eq("busy_after_start", busy, n != 0);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      if (inject && i == 2) begin
        start = 1'b1;
        base_addr = 6'd10;
        len = 7'd3;
      end else if (inject && i == 3) begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check_eq("done_seen", done_cnt, 1);
    check_eq("done_time", done_cyc, (n == 0) ? start_cyc : last_hs_cyc + 1);
    check_eq("sb_drained", exp_q.size(), 0);
    check_eq("word_count", hs_cnt, int'(n));
    if (mode == 0 && n != 0) begin
      check_eq("first_latency", first_valid_cyc - start_cyc, 2);
      check_eq("back_to_back", last_hs_cyc - first_valid_cyc, int'(n) - 1);
    end
    step();
    check_eq("done_one_cycle", done, 0);
    check_eq("done_pulse_count", done_cnt, 1);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) ^ 8'h5A;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    m_ready = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_last", m_last, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("ram_we_zero", ram_we, 0);
    check_eq("ram_din_zero", ram_din, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Basic burst, consumer always ready.
    mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'h11; mem[4] = 8'h22;
    run_burst(6'd1, 7'd4, 0, 1'b0);
    // Same burst with a stalling consumer.
    run_burst(6'd1, 7'd4, 1, 1'b0);
    // Address wrap-around.
    mem[62] = 8'h01; mem[63] = 8'h02; mem[0] = 8'h03; mem[1] = 8'h04;
    run_burst(6'd62, 7'd4, 0, 1'b0);
    // Zero-length command.
    run_burst(6'd7, 7'd0, 0, 1'b0);

    // Reset while the third word of a len=8 burst is presented.
    rdy_mode = 0;
    cur_base = 6'd0;
    hs_cnt = 0;
    done_cnt = 0;
    push_expect(6'd0, 8);
    base_addr = 6'd0;
    len = 7'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 50 && hs_cnt < 3; i++) step();
    check_eq("reach_third_word", hs_cnt, 3);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_m_valid", m_valid, 0);
    check_eq("abort_m_last", m_last, 0);
    check_eq("abort_m_data", m_data, 0);
    check_eq("abort_ram_addr", ram_addr, 0);
    exp_q.delete();
    stall_prev = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_no_valid", m_valid, 0);
    run_burst(6'd3, 7'd1, 0, 1'b0);

    // Start pulse while busy is ignored.
    run_burst(6'd20, 7'd8, 1, 1'b1);
    // Full-depth burst reads every location once.
    run_burst(6'd5, 7'd64, 0, 1'b0);

    check_eq("ram_we_end", ram_we, 0);
    check_eq("ram_din_end", ram_din, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
